// File: rtl/subband_serializer_pkg.sv
// Shared widths, saturation limits and FSM state encoding for the
// filter-bank band serializer.
package subband_pkg;

  localparam int NUM_BANDS  = 16;
  localparam int IN_W       = 33;
  localparam int OUT_W      = 16;
  localparam int BAND_IDX_W = 4;

  localparam logic [OUT_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [OUT_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/subband_serializer_if.sv
// Narrow valid/ready beat stream carrying one requantised band per beat.
interface subband_serializer_if;
  import subband_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic [BAND_IDX_W-1:0] out_band;
  logic                  out_last;
  logic                  out_sat;

  modport master (
    output out_valid, out_data, out_band, out_last, out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_band, out_last, out_sat,
    output out_ready
  );

endinterface

// File: rtl/subband_serializer_sat_round_q.sv
// Combinational gain shift, round-half-up and saturation from a 33-bit
// Q.32 band sample down to a 16-bit Q.15 output sample.
module sat_round_q
  import subband_pkg::*;
#(
  parameter int GAIN_SHIFT = 0
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y,
  output logic             sat
);

  localparam int YW = IN_W + GAIN_SHIFT + 1;
  localparam int S  = IN_W - OUT_W;
  localparam logic signed [YW-1:0] HALF = {{(YW-S){1'b0}}, 1'b1, {(S-1){1'b0}}};

  logic signed [YW-1:0] w_ext;
  logic signed [YW-1:0] w_rnd;
  logic signed [YW-1:0] w_sh;
  logic                 w_ovf;

  // One spare top bit keeps the rounding add from wrapping.
  assign w_ext = $signed({{(GAIN_SHIFT+1){x[IN_W-1]}}, x}) <<< GAIN_SHIFT;
  assign w_rnd = w_ext + HALF;
  assign w_sh  = w_rnd >>> S;

  // In range only if everything above the output sign bit is a sign copy.
  assign w_ovf = !((&w_sh[YW-1:OUT_W-1]) || !(|w_sh[YW-1:OUT_W-1]));

  assign sat = w_ovf;
  assign y   = w_ovf ? (w_sh[YW-1] ? SAT_MIN : SAT_MAX) : w_sh[OUT_W-1:0];

endmodule

// File: rtl/subband_serializer.sv
// Snapshots all 16 filter-bank bands on in_valid and streams them out,
// requantised, one band per valid/ready beat, band 0 first.
//   state | meaning
//   IDLE  | no set held, waiting for in_valid
//   SEND  | presenting snapshot beats, band r_band on the output
module subband_serializer
  import subband_pkg::*;
#(
  parameter int GAIN_SHIFT = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [NUM_BANDS*IN_W-1:0] in_data,
  input  logic                      clear_overrun,
  output logic                      overrun,
  subband_serializer_if.master      o_stream
);

  state_t                r_state;
  logic [BAND_IDX_W-1:0] r_band;
  logic [IN_W-1:0]       r_snap [NUM_BANDS];
  logic [OUT_W-1:0]      r_data;
  logic                  r_last;
  logic                  r_sat;
  logic                  r_overrun;

  logic                  w_xfer;
  logic                  w_end;
  logic                  w_capture;
  logic                  w_drop;
  logic [BAND_IDX_W-1:0] w_next_band;
  logic [IN_W-1:0]       w_x;
  logic [OUT_W-1:0]      w_q;
  logic                  w_sat;

  assign w_xfer      = (r_state == SEND) && o_stream.out_ready;
  assign w_end       = w_xfer && (r_band == BAND_IDX_W'(NUM_BANDS-1));
  assign w_capture   = in_valid && ((r_state == IDLE) || w_end);
  assign w_drop      = in_valid && (r_state == SEND) && !w_end;
  assign w_next_band = r_band + 1'b1;

  // On capture the first beat is quantised straight from the incoming set,
  // otherwise from the snapshot entry that becomes current next cycle.
  assign w_x = w_capture ? in_data[IN_W-1:0] : r_snap[w_next_band];

  sat_round_q #(.GAIN_SHIFT(GAIN_SHIFT)) u_q (
    .x   (w_x),
    .y   (w_q),
    .sat (w_sat)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_band    <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_sat     <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) r_snap[k] <= '0;
    end else begin
      if (w_capture) begin
        for (int k = 0; k < NUM_BANDS; k++) r_snap[k] <= in_data[IN_W*k +: IN_W];
        r_state <= SEND;
        r_band  <= '0;
        r_data  <= w_q;
        r_sat   <= w_sat;
        r_last  <= 1'b0;
      end else if (w_end) begin
        r_state <= IDLE;
        r_band  <= '0;
        r_data  <= '0;
        r_sat   <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_xfer) begin
        r_band  <= w_next_band;
        r_data  <= w_q;
        r_sat   <= w_sat;
        r_last  <= (w_next_band == BAND_IDX_W'(NUM_BANDS-1));
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)             r_overrun <= 1'b1;
      else if (clear_overrun) r_overrun <= 1'b0;
    end
  end

  assign o_stream.out_valid = (r_state == SEND);
  assign o_stream.out_data  = r_data;
  assign o_stream.out_band  = r_band;
  assign o_stream.out_last  = r_last;
  assign o_stream.out_sat   = r_sat;
  assign overrun            = r_overrun;

endmodule
